// File: rtl/seven_seg_capture.sv
// seven_seg_capture: receive side of the two-digit multiplexed 7-seg driver.
// Rebuilds the displayed 8-bit hex value from the anode/LED bus.
module seven_seg_capture #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned TIMEOUT       = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       anode,
   input  logic [6:0] LED,
   output logic [7:0] char_out,
   output logic       char_valid,
   output logic       seg_err,
   output logic       in_sync
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [3:0]    SCNT_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      WAIT_EDGE
   } state_t;

   state_t        state_q;
   logic          anode_r_q;
   logic          anode_q;
   logic [6:0]    led_r_q;
   logic [3:0]    scnt_q;
   logic [TW-1:0] tcnt_q;
   logic [TW-1:0] tcnt_d;
   logic [3:0]    hi_q;
   logic          hi_ok_q;
   logic          pend_q;
   logic [7:0]    char_q;
   logic          valid_q;
   logic          err_q;
   logic          sync_q;

   logic          edge_det;
   logic          rise_det;
   logic [3:0]    dec_nib;
   logic          dec_ok;

   assign edge_det = anode_r_q ^ anode_q;
   assign rise_det = anode_r_q & ~anode_q;

   // Saturating next value of the no-edge timeout counter
   always_comb begin
      tcnt_d = tcnt_q;
      if (tcnt_q != TMAX) begin
         tcnt_d = tcnt_q + 1'b1;
      end
   end

   // Segment pattern back to nibble; anything off-table is flagged
   always_comb begin
      dec_ok  = 1'b1;
      dec_nib = 4'h0;
      unique case (led_r_q)
         7'h7E:   dec_nib = 4'h0;
         7'h30:   dec_nib = 4'h1;
         7'h6D:   dec_nib = 4'h2;
         7'h79:   dec_nib = 4'h3;
         7'h33:   dec_nib = 4'h4;
         7'h5B:   dec_nib = 4'h5;
         7'h5F:   dec_nib = 4'h6;
         7'h70:   dec_nib = 4'h7;
         7'h7F:   dec_nib = 4'h8;
         7'h7B:   dec_nib = 4'h9;
         7'h77:   dec_nib = 4'hA;
         7'h1F:   dec_nib = 4'hB;
         7'h4E:   dec_nib = 4'hC;
         7'h3D:   dec_nib = 4'hD;
         7'h4F:   dec_nib = 4'hE;
         7'h47:   dec_nib = 4'hF;
         default: dec_ok  = 1'b0;
      endcase
   end

   // Input registers, edge history and the receive FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         anode_r_q <= 1'b0;
         anode_q   <= 1'b0;
         led_r_q   <= 7'h00;
         scnt_q    <= 4'h0;
         tcnt_q    <= '0;
         hi_q      <= 4'h0;
         hi_ok_q   <= 1'b0;
         pend_q    <= 1'b0;
         char_q    <= 8'h00;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         anode_r_q <= anode;
         anode_q   <= anode_r_q;
         led_r_q   <= LED;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         pend_q    <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (rise_det) begin
                  state_q <= SETTLE;
                  scnt_q  <= 4'h0;
               end
            end
            SETTLE: begin
               if (edge_det) begin
                  scnt_q <= 4'h0;
               end else if (scnt_q == SCNT_LAST) begin
                  state_q <= SAMPLE;
               end else begin
                  scnt_q <= scnt_q + 1'b1;
               end
            end
            SAMPLE: begin
               // An edge arriving now is replayed in WAIT_EDGE
               pend_q <= edge_det;
               tcnt_q <= '0;
               if (!dec_ok) begin
                  err_q   <= 1'b1;
                  hi_ok_q <= 1'b0;
                  sync_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (anode_r_q) begin
                  hi_q    <= dec_nib;
                  hi_ok_q <= 1'b1;
                  sync_q  <= 1'b1;
                  state_q <= WAIT_EDGE;
               end else begin
                  if (hi_ok_q) begin
                     char_q  <= {hi_q, dec_nib};
                     valid_q <= 1'b1;
                  end
                  hi_ok_q <= 1'b0;
                  state_q <= WAIT_EDGE;
               end
            end
            WAIT_EDGE: begin
               if (edge_det || pend_q) begin
                  tcnt_q  <= '0;
                  scnt_q  <= 4'h0;
                  state_q <= SETTLE;
               end else if (tcnt_d == TMAX) begin
                  tcnt_q  <= tcnt_d;
                  hi_ok_q <= 1'b0;
                  sync_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  tcnt_q <= tcnt_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign char_out   = char_q;
   assign char_valid = valid_q;
   assign seg_err    = err_q;
   assign in_sync    = sync_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: driver model feeds the capture block; expected
// frames go into a queue that a negedge monitor drains on char_valid.
module tb_seven_seg_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic       anode;
   logic [6:0] LED;
   logic [7:0] char_out;
   logic       char_valid;
   logic       seg_err;
   logic       in_sync;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_cyc = -1;
   int seg_cnt = 0;
   int exp_seg = 0;
   bit chk_period = 1'b0;
   logic [7:0] expq[$];

   seven_seg_capture #(
      .SETTLE_CYCLES(2),
      .TIMEOUT(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .anode(anode),
      .LED(LED),
      .char_out(char_out),
      .char_valid(char_valid),
      .seg_err(seg_err),
      .in_sync(in_sync)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [6:0] seg(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0: p = 7'h7E;
         4'h1: p = 7'h30;
         4'h2: p = 7'h6D;
         4'h3: p = 7'h79;
         4'h4: p = 7'h33;
         4'h5: p = 7'h5B;
         4'h6: p = 7'h5F;
         4'h7: p = 7'h70;
         4'h8: p = 7'h7F;
         4'h9: p = 7'h7B;
         4'hA: p = 7'h77;
         4'hB: p = 7'h1F;
         4'hC: p = 7'h4E;
         4'hD: p = 7'h3D;
         4'hE: p = 7'h4F;
         default: p = 7'h47;
      endcase
      return p;
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input logic a, input logic [6:0] p, input int n);
      anode = a;
      LED   = p;
      tick(n);
   endtask

   task automatic frame(input logic [7:0] v, input bit out);
      if (out) expq.push_back(v);
      show(1'b1, seg(v[7:4]), 16);
      show(1'b0, seg(v[3:0]), 16);
   endtask

   // Monitor: pop and compare on every char_valid, track pulse spacing
   always @(negedge clk) begin
      if (char_valid) begin
         if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid: got char_out %0h expected none (cycle %0d)",
                     char_out, cyc);
         end else begin
            check("char_out", char_out, expq.pop_front());
         end
         if (chk_period && last_cyc >= 0)
            check("valid_period", cyc - last_cyc, 32);
         last_cyc = chk_period ? cyc : -1;
      end else if (!chk_period) begin
         last_cyc = -1;
      end
      if (seg_err) seg_cnt++;
   end

   initial begin
      rst   = 1'b0;
      anode = 1'b0;
      LED   = 7'h00;
      tick(3);
      check("rst_char_out", char_out, 8'h00);
      check("rst_char_valid", char_valid, 0);
      check("rst_seg_err", seg_err, 0);
      check("rst_in_sync", in_sync, 0);
      rst = 1'b1;
      tick(2);

      // 3A frames, exact latency of the first pulse, 32-clk spacing
      chk_period = 1'b1;
      expq.push_back(8'h3A);
      show(1'b1, seg(4'h3), 2);
      check("sync_before_hi", in_sync, 0);
      show(1'b1, seg(4'h3), 14);
      check("sync_after_hi", in_sync, 1);
      show(1'b0, seg(4'hA), 4);
      check("valid_early", char_valid, 0);
      tick(1);
      check("valid_on_time", char_valid, 1);
      tick(11);
      for (int i = 0; i < 3; i++) frame(8'h3A, 1'b1);

      // Full sweep
      for (int i = 0; i < 256; i++) frame(8'(i), 1'b1);
      chk_period = 1'b0;

      // Blank high phase: seg_err, sync lost, value held
      show(1'b1, 7'h00, 16);
      exp_seg++;
      check("err_sync_drop", in_sync, 0);
      check("err_hold_char", char_out, 8'hFF);
      show(1'b0, seg(4'h0), 16);
      check("err_low_ignored", in_sync, 0);
      frame(8'h5E, 1'b1);
      check("err_recover_sync", in_sync, 1);

      // Anode stuck high: timeout
      show(1'b1, seg(4'h9), 20);
      check("to_sync_early", in_sync, 1);
      show(1'b1, seg(4'h9), 80);
      check("to_sync_drop", in_sync, 0);
      check("to_hold_char", char_out, 8'h5E);
      show(1'b0, seg(4'h2), 16);
      frame(8'h92, 1'b1);

      // Reset between high and low samples of C5
      show(1'b1, seg(4'hC), 16);
      check("c5_sync_hi", in_sync, 1);
      anode = 1'b0;
      LED   = seg(4'h5);
      tick(2);
      rst = 1'b0;
      tick(1);
      check("mid_rst_char", char_out, 8'h00);
      check("mid_rst_sync", in_sync, 0);
      rst = 1'b1;
      tick(13);
      check("post_rst_char", char_out, 8'h00);
      frame(8'hC5, 1'b1);
      check("c5_final", char_out, 8'hC5);

      // One-clock anode glitch inside SETTLE
      expq.push_back(8'hA7);
      show(1'b1, seg(4'hA), 2);
      show(1'b0, seg(4'h7), 1);
      show(1'b1, seg(4'hA), 13);
      show(1'b0, seg(4'h7), 16);
      check("glitch_char", char_out, 8'hA7);

      tick(5);
      check("queue_empty", expq.size(), 0);
      check("seg_err_count", seg_cnt, exp_seg);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
